// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, arbiter and dmem pins of the data-memory
// arbiter, bundled so the arbiter takes one bus port.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_we, mem_din,
    input  mem_dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport mem (
    input  mem_addr, mem_we, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority m0 / debug m1 arbiter for the 1-cycle dmem,
// with m1 starvation guard and burst lock. DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0] stat_m0_cnt,
  output logic [31:0] stat_m1_cnt,
  output logic [31:0] stat_stall_cnt,
`endif
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] OWN_M0      = 2'd1;
  localparam logic [1:0] OWN_M1_LOCK = 2'd2;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              pend_q, pend_d;
  logic              tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              win0, win1;
  logic              gnt0, gnt1;
  logic              rv0, rv1;

  // Pick the winner: lock owner first, then starvation, then m0 priority
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state_q == OWN_M1_LOCK) begin
      win1 = bus.m1_req;
    end else if (starve_q == SMAX && bus.m1_req) begin
      win1 = 1'b1;
    end else if (bus.m0_req) begin
      win0 = 1'b1;
    end else begin
      win1 = bus.m1_req;
    end
  end

  assign gnt0 = win0 & rst;
  assign gnt1 = win1 & rst;

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  assign bus.mem_addr = gnt1 ? bus.m1_addr :
                        gnt0 ? bus.m0_addr : addr_q;
  assign bus.mem_we   = (gnt1 & bus.m1_we) | (gnt0 & bus.m0_we);
  assign bus.mem_din  = gnt1 ? bus.m1_wdata :
                        gnt0 ? bus.m0_wdata : '0;

  assign rv0 = pend_q & ~tag_q;
  assign rv1 = pend_q & tag_q;

  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? bus.mem_dout : rd0_q;
  assign bus.m1_rdata  = rv1 ? bus.mem_dout : rd1_q;

  // Starvation count, ownership state and read tag for next cycle
  always_comb begin
    starve_d = '0;
    if (bus.m1_req && !gnt1) begin
      starve_d = (starve_q == SMAX) ? SMAX : starve_q + 4'd1;
    end
    state_d = IDLE;
    if (gnt1 && bus.m1_lock) begin
      state_d = OWN_M1_LOCK;
    end else if (gnt0) begin
      state_d = OWN_M0;
    end
    pend_d = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
    tag_d  = gnt1;
  end

  // Arbiter state, read pipeline and held address/read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      pend_q   <= 1'b0;
      tag_q    <= 1'b0;
      addr_q   <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
      addr_q   <= bus.mem_addr;
      if (rv0) rd0_q <= bus.mem_dout;
      if (rv1) rd1_q <= bus.mem_dout;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic stall;

  assign stall = (bus.m0_req & ~gnt0) | (bus.m1_req & ~gnt1);

  // Free-running grant and stall counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_m0_cnt    <= '0;
      stat_m1_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (gnt0)  stat_m0_cnt    <= stat_m0_cnt + 32'd1;
      if (gnt1)  stat_m1_cnt    <= stat_m1_cnt + 32'd1;
      if (stall) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a
// write-first behavioural dmem.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  logic [31:0] mem [0:2047];

  dmem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] s_m0, s_m1, s_st;
`endif

  dmem_arbiter #(
    .ADDR_W(11),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef DMEM_ARB_STATS_EN
    .stat_m0_cnt(s_m0),
    .stat_m1_cnt(s_m1),
    .stat_stall_cnt(s_st),
`endif
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= bus.mem_we ? bus.mem_din : mem[bus.mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req  = 1'b0;
    bus.m0_we   = 1'b0;
    bus.m1_req  = 1'b0;
    bus.m1_we   = 1'b0;
    bus.m1_lock = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[16] = 32'hDEAD_BEEF;
    bus.mem_dout = '0;
    bus.m0_addr  = '0;
    bus.m0_wdata = '0;
    bus.m1_addr  = '0;
    bus.m1_wdata = '0;
    idle();
    rst = 1'b0;

    // reset with requests pending
    bus.m0_req  = 1'b1;
    bus.m0_addr = 11'h010;
    bus.m1_req  = 1'b1;
    bus.m1_we   = 1'b1;
    tick();
    tick();
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rv0", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_rv1", 32'(bus.m1_rvalid), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);

    // first load after release
    rst = 1'b1;
    bus.m1_req = 1'b0;
    bus.m1_we  = 1'b0;
    #1;
    chk("ld0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("ld0_addr", 32'(bus.mem_addr), 32'h010);
    tick();
    chk("ld0_rv", 32'(bus.m0_rvalid), 32'd1);
    chk("ld0_data", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("ld0_rv1", 32'(bus.m1_rvalid), 32'd0);
    idle();
    #1;
    chk("hold_addr", 32'(bus.mem_addr), 32'h010);
    chk("hold_we", 32'(bus.mem_we), 32'd0);
    chk("hold_gnt", 32'(bus.m0_gnt), 32'd0);
    tick();

    // both requesting: starvation guard every fifth cycle
    bus.m0_req  = 1'b1;
    bus.m0_addr = 11'h040;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 11'h041;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stv_g0_%0d", i), 32'(bus.m0_gnt),
          (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("stv_g1_%0d", i), 32'(bus.m1_gnt),
          (i % 5 == 4) ? 32'd1 : 32'd0);
      tick();
      if (i % 5 == 4) begin
        chk($sformatf("stv_rv1_%0d", i), 32'(bus.m1_rvalid), 32'd1);
        chk($sformatf("stv_d1_%0d", i), bus.m1_rdata, 32'hA000_0041);
      end
    end
    idle();
    tick();

    // m1 locked burst of three stores
    bus.m1_req   = 1'b1;
    bus.m1_lock  = 1'b1;
    bus.m1_we    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.m1_addr  = 11'(11'h020 + i);
      bus.m1_wdata = 32'hB000_0020 + 32'(i);
      #1;
      chk($sformatf("lk_g1_%0d", i), 32'(bus.m1_gnt), 32'd1);
      chk($sformatf("lk_g0_%0d", i), 32'(bus.m0_gnt), 32'd0);
      chk($sformatf("lk_we_%0d", i), 32'(bus.mem_we), 32'd1);
      tick();
      bus.m0_req  = 1'b1;
      bus.m0_addr = 11'h050;
    end
    bus.m1_req  = 1'b0;
    bus.m1_lock = 1'b0;
    bus.m1_we   = 1'b0;
    #1;
    chk("lk_drop_g0", 32'(bus.m0_gnt), 32'd0);
    tick();
    chk("lk_after_g0", 32'(bus.m0_gnt), 32'd1);
    chk("lk_after_addr", 32'(bus.mem_addr), 32'h050);
    tick();
    chk("lk_after_d", bus.m0_rdata, 32'hA000_0050);
    bus.m0_addr = 11'h021;
    #1;
    chk("lk_rb_gnt", 32'(bus.m0_gnt), 32'd1);
    tick();
    chk("lk_rb_data", bus.m0_rdata, 32'hB000_0021);
    idle();
    tick();

    // alternating back-to-back loads
    bus.m0_req  = 1'b1;
    bus.m0_addr = 11'h005;
    tick();
    bus.m0_req  = 1'b0;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 11'h006;
    chk("alt_rv0_a", 32'(bus.m0_rvalid), 32'd1);
    chk("alt_d0_a", bus.m0_rdata, 32'hA000_0005);
    tick();
    bus.m1_req  = 1'b0;
    bus.m0_req  = 1'b1;
    bus.m0_addr = 11'h007;
    chk("alt_rv1", 32'(bus.m1_rvalid), 32'd1);
    chk("alt_rv0_b", 32'(bus.m0_rvalid), 32'd0);
    chk("alt_d1", bus.m1_rdata, 32'hA000_0006);
    chk("alt_d0_hold", bus.m0_rdata, 32'hA000_0005);
    tick();
    idle();
    chk("alt_rv0_c", 32'(bus.m0_rvalid), 32'd1);
    chk("alt_d0_c", bus.m0_rdata, 32'hA000_0007);
    tick();

    // store then load through the other port
    bus.m0_req   = 1'b1;
    bus.m0_we    = 1'b1;
    bus.m0_addr  = 11'h030;
    bus.m0_wdata = 32'h1234_5678;
    #1;
    chk("st_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("st_we", 32'(bus.mem_we), 32'd1);
    chk("st_din", bus.mem_din, 32'h1234_5678);
    tick();
    chk("st_rv0", 32'(bus.m0_rvalid), 32'd0);
    chk("st_rv1", 32'(bus.m1_rvalid), 32'd0);
    idle();
    bus.m1_req  = 1'b1;
    bus.m1_addr = 11'h030;
    #1;
    chk("st_ld_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    idle();
    chk("st_ld_rv1", 32'(bus.m1_rvalid), 32'd1);
    chk("st_ld_d1", bus.m1_rdata, 32'h1234_5678);
    chk("st_ld_d0", bus.m0_rdata, 32'hA000_0007);
    tick();

    // reset during a locked m1 load
    bus.m1_req  = 1'b1;
    bus.m1_lock = 1'b1;
    bus.m1_addr = 11'h010;
    #1;
    chk("rl_gnt", 32'(bus.m1_gnt), 32'd1);
    #1;
    rst = 1'b0;
    tick();
    chk("rl_rv1", 32'(bus.m1_rvalid), 32'd0);
    chk("rl_g1", 32'(bus.m1_gnt), 32'd0);
    bus.m0_req  = 1'b1;
    bus.m0_addr = 11'h060;
    tick();
    rst = 1'b1;
    #1;
    chk("rl_rel_g0", 32'(bus.m0_gnt), 32'd1);
    chk("rl_rel_g1", 32'(bus.m1_gnt), 32'd0);
    chk("rl_rel_rv1", 32'(bus.m1_rvalid), 32'd0);
    tick();
    chk("rl_rv0", 32'(bus.m0_rvalid), 32'd1);
    chk("rl_d0", bus.m0_rdata, 32'hA000_0060);
    chk("rl_rv1_b", 32'(bus.m1_rvalid), 32'd0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
